sm4_input_packer: RTL and testbench
===================================

// Module: sm4_input_packer
// PURPOSE
//   Upstream feeder for sm4_encryptor. Accepts a 32-bit word stream of key and data words
//   over valid/ready, assembles 128-bit key and content groups (first word -> bits [127:96]),
//   and presents one group plus mode to the encryptor's v_i/ready_o handshake.
//   Each key commit pulses invalid_cache_o so the encryptor drops round keys expanded from the old key.
// PARAMETERS
//   word_width_p   32              input word width; group_size_p % word_width_p == 0
//   group_size_p   (pkg) 128       SM4 group width, taken from sm4_encryptor_pkg
//   words_lp       derived         group_size_p/word_width_p (4); local, not overridable
// PORTS
//   clk_i              in   1     clock, rising edge
//   reset_i            in   1     asynchronous, active-high reset
//   clear_i            in   1     synchronous abort: drop partial key/data, go COLLECT
//   word_i             in   32    input word
//   word_is_key_i      in   1     1 = key word, 0 = data word
//   encode_or_decode_i in   1     mode (decode is 1); sampled with the first data word of a group
//   v_i                in   1     word valid
//   ready_o            out  1     word accepted when v_i & ready_o
//   content_o          out  128   assembled data group -> encryptor content_i
//   key_o              out  128   committed key -> encryptor key_i
//   encode_or_decode_o out  1     mode of the presented group
//   v_o                out  1     group valid -> encryptor v_i
//   ready_i            in   1     encryptor ready_o; group transfers when v_o & ready_i
//   invalid_cache_o    out  1     one-cycle pulse on key commit -> encryptor invalid_cache_i
//   key_valid_o        out  1     a full key has been committed since reset/clear
// BEHAVIOUR
//   Reset: state COLLECT; both word counters 0; content_o, key_o, encode_or_decode_o 0;
//     v_o 0; invalid_cache_o 0; key_valid_o 0. ready_o is 1 on the first clock after reset release.
//   Packing: counter k selects the slice. Word k goes to bits [127-32k -: 32]. Key and data use
//     separate counters and shadow registers, so key and data words may interleave freely.
//   Key commit: on the cycle after the 4th key word is accepted, key_o <= shadow,
//     key_valid_o <= 1, and invalid_cache_o = 1 for exactly that one cycle.
//     The key counter wraps to 0. The commit pulses even if the key value is unchanged.
//   FSM (packer_state_e):
//     COLLECT: ready_o = 1. On the 4th data word accepted -> SEND if key_valid_o is 1,
//       or if a key commit lands in that same cycle; otherwise -> HOLD.
//     HOLD: ready_o = word_is_key_i (only key words accepted; combinational path from the input).
//       Goes to SEND on the cycle after key_valid_o becomes 1.
//     SEND: v_o = 1 and ready_o = 0. content_o, key_o and mode are stable.
//       On v_o & ready_i -> COLLECT, with ready_o = 1 in the next cycle.
//   Latency: 4th data word accepted in cycle N (valid key) -> v_o = 1 in N+1.
//     v_o is registered, with no combinational path from ready_i.
//   Key words are never accepted in SEND, so key_o cannot change under a pending group.
//   clear_i has priority over all transfers in the same cycle:
//     counters go to 0, state goes to COLLECT, v_o goes to 0, key_o/key_valid_o are kept,
//     and no invalid_cache_o pulse is issued.
//   Async reset mid-group or mid-key discards everything, including the committed key.
//   Mode is latched with data word 0. A mode change on words 1-3 is ignored.
// STRUCTURE
//   sm4_encryptor_pkg gains: typedef enum logic [1:0] {COLLECT, HOLD, SEND} packer_state_e;
//     plus localparam sm4_word_width_p = 32.
//   Sub-module sm4_word_accumulator (count, shift-in, full flag; width params) is instantiated
//     twice, once for key words and once for data words. The FSM and handshake stay in the top.
// TESTING
//   1 Key 01234567,89abcdef,fedcba98,76543210 then data with the same words, ready_i = 1:
//     key_o = content_o = 0123456789abcdeffedcba9876543210; invalid_cache_o pulses once;
//     v_o rises one cycle after the 4th data word.
//   2 Data first (4 words) with no key: state HOLD, ready_o = 0 for data, 1 for key words.
//     After 4 key words: the key commit cycle is followed by v_o = 1.
//   3 Group pending with ready_i = 0 for 10 cycles: v_o, content_o and key_o hold steady,
//     ready_o = 0; ready_i = 1 -> one transfer, ready_o = 1 in the next cycle.
//   4 Interleave K0,D0,K1,D1,K2,D2,K3,D3: both groups assemble correctly; SEND follows commit.
//   5 clear_i after 2 data words, then 4 fresh data words: content_o holds only the fresh words;
//     key_o is kept and no invalid_cache_o pulse occurs.
//   6 reset_i asserted asynchronously mid-SEND: v_o, key_valid_o and key_o drop to 0
//     immediately; ready_o = 1 after release.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
//------------------------------------------------------------------------------
// Module   : sm4_encryptor_pkg
// Brief    : Shared SM4 widths and the input packer state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sm4_encryptor_pkg;

  // SM4 operates on 128-bit groups; the feeder bus carries 32-bit words.
  localparam int sm4_group_size_p = 128;
  localparam int sm4_word_width_p = 32;

  // Input packer control states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    SEND    = 2'd2
  } packer_state_e;

endpackage

`default_nettype wire

// File: rtl/sm4_word_accumulator.sv
//------------------------------------------------------------------------------
// Module   : sm4_word_accumulator
// Brief    : Collects words_p words into one wide group, first word in the
//            most significant slice. Reports the next shadow value so the
//            owner can capture a complete group on the cycle the last word
//            arrives.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm4_word_accumulator
  import sm4_encryptor_pkg::*;
#(
  parameter int width_p = sm4_word_width_p,
  parameter int words_p = sm4_group_size_p / sm4_word_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       shift_i,
  input  logic [width_p-1:0]         word_i,
  output logic [width_p*words_p-1:0] data_o,
  output logic                       first_o,
  output logic                       full_o
);

  localparam int total_lp = width_p * words_p;
  localparam int cnt_w_lp = (words_p > 1) ? $clog2(words_p) : 1;

  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [total_lp-1:0] data_q, data_d;
  logic                shift_en;
  logic                is_last;

  // A clear in the same cycle wins over an incoming word.
  assign shift_en = shift_i & ~clear_i;
  assign is_last  = (count_q == cnt_w_lp'(words_p - 1));
  assign first_o  = (count_q == '0);
  assign full_o   = shift_en & is_last;
  assign data_o   = data_d;

  // Drop the accepted word into the slice selected by the word counter.
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < words_p; k++) begin
      if (shift_en && (count_q == cnt_w_lp'(k))) begin
        data_d[total_lp-1-width_p*k -: width_p] = word_i;
      end
    end
  end

  // Word counter: wraps after the last slice, returns to 0 on clear.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (shift_en) begin
      count_d = is_last ? '0 : count_q + 1'b1;
    end
  end

  // Counter and shadow group registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sm4_input_packer.sv
//------------------------------------------------------------------------------
// Module   : sm4_input_packer
// Brief    : Packs a 32-bit key/data word stream into 128-bit key and content
//            groups for sm4_encryptor, with a key-commit cache invalidate
//            pulse and a registered group valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm4_input_packer
  import sm4_encryptor_pkg::*;
#(
  parameter int word_width_p = sm4_word_width_p,
  parameter int group_size_p = sm4_group_size_p
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic [word_width_p-1:0] word_i,
  input  logic                    word_is_key_i,
  input  logic                    encode_or_decode_i,
  input  logic                    v_i,
  output logic                    ready_o,
  output logic [group_size_p-1:0] content_o,
  output logic [group_size_p-1:0] key_o,
  output logic                    encode_or_decode_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic                    invalid_cache_o,
  output logic                    key_valid_o
);

  localparam int words_lp = group_size_p / word_width_p;

  packer_state_e state_q, state_d;

  logic [group_size_p-1:0] key_q, content_q;
  logic [group_size_p-1:0] key_next, data_next;
  logic                    mode_q, mode_first_q;
  logic                    key_valid_q, inv_q;
  logic                    accept, key_shift, data_shift;
  logic                    key_full, data_full, data_first;
  logic                    key_first_unused;

  assign accept     = v_i & ready_o;
  assign key_shift  = accept &  word_is_key_i & ~clear_i;
  assign data_shift = accept & ~word_is_key_i & ~clear_i;

  sm4_word_accumulator #(
    .width_p (word_width_p),
    .words_p (words_lp)
  ) u_key_acc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .shift_i (key_shift),
    .word_i  (word_i),
    .data_o  (key_next),
    .first_o (key_first_unused),
    .full_o  (key_full)
  );

  sm4_word_accumulator #(
    .width_p (word_width_p),
    .words_p (words_lp)
  ) u_data_acc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .shift_i (data_shift),
    .word_i  (word_i),
    .data_o  (data_next),
    .first_o (data_first),
    .full_o  (data_full)
  );

  // Word-side handshake: HOLD only lets key words through, SEND blocks all.
  always_comb begin
    ready_o = 1'b0;
    case (state_q)
      COLLECT: ready_o = 1'b1;
      HOLD:    ready_o = word_is_key_i;
      default: ready_o = 1'b0;
    endcase
  end

  // Next-state logic; a clear forces COLLECT regardless of any transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (data_full) begin
          state_d = (key_valid_q || key_full) ? SEND : HOLD;
        end
      end
      HOLD: begin
        if (key_valid_q) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (clear_i) begin
      state_d = COLLECT;
    end
  end

  // State, committed groups, mode and the key-commit pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= COLLECT;
      key_q        <= '0;
      content_q    <= '0;
      mode_q       <= 1'b0;
      mode_first_q <= 1'b0;
      key_valid_q  <= 1'b0;
      inv_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= key_full;
      if (key_full) begin
        key_q       <= key_next;
        key_valid_q <= 1'b1;
      end
      if (data_shift && data_first) begin
        mode_first_q <= encode_or_decode_i;
      end
      if (data_full) begin
        content_q <= data_next;
        mode_q    <= data_first ? encode_or_decode_i : mode_first_q;
      end
    end
  end

  assign v_o                = (state_q == SEND);
  assign content_o          = content_q;
  assign key_o              = key_q;
  assign encode_or_decode_o = mode_q;
  assign invalid_cache_o    = inv_q;
  assign key_valid_o        = key_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sm4_input_packer.sv
//------------------------------------------------------------------------------
// Module   : tb_sm4_input_packer
// Brief    : Directed table-driven bench for sm4_input_packer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm4_input_packer;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         clear_i = 1'b0;
  logic [31:0]  word_i = '0;
  logic         word_is_key_i = 1'b0;
  logic         encode_or_decode_i = 1'b0;
  logic         v_i = 1'b0;
  logic         ready_o;
  logic [127:0] content_o;
  logic [127:0] key_o;
  logic         encode_or_decode_o;
  logic         v_o;
  logic         ready_i = 1'b0;
  logic         invalid_cache_o;
  logic         key_valid_o;

  int total = 0;
  int bad   = 0;

  sm4_input_packer dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .clear_i            (clear_i),
    .word_i             (word_i),
    .word_is_key_i      (word_is_key_i),
    .encode_or_decode_i (encode_or_decode_i),
    .v_i                (v_i),
    .ready_o            (ready_o),
    .content_o          (content_o),
    .key_o              (key_o),
    .encode_or_decode_o (encode_or_decode_o),
    .v_o                (v_o),
    .ready_i            (ready_i),
    .invalid_cache_o    (invalid_cache_o),
    .key_valid_o        (key_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          rst;
    bit          v;
    bit          key;
    logic [31:0] word;
    bit          mode;
    bit          rdy;
    bit          clr;
    bit          e_ready;
    bit          e_v;
    bit          e_inv;
    bit          e_kval;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(bit rst, bit v, bit key, logic [31:0] word, bit mode, bit rdy,
                              bit e_ready, bit e_v, bit e_inv, bit e_kval);
    vec_t r;
    r.rst = rst; r.v = v; r.key = key; r.word = word; r.mode = mode; r.rdy = rdy; r.clr = 1'b0;
    r.e_ready = e_ready; r.e_v = e_v; r.e_inv = e_inv; r.e_kval = e_kval;
    tbl.push_back(r);
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(bit v, bit key, logic [31:0] word, bit mode, bit rdy, bit clr);
    @(negedge clk_i);
    v_i = v; word_is_key_i = key; word_i = word;
    encode_or_decode_i = mode; ready_i = rdy; clear_i = clr;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    v_i = 1'b0; clear_i = 1'b0; ready_i = 1'b0; word_is_key_i = 1'b0;
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) pulse_reset();
      drive(tbl[i].v, tbl[i].key, tbl[i].word, tbl[i].mode, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("%s[%0d].ready_o", tag, i), ready_o, tbl[i].e_ready);
      chk($sformatf("%s[%0d].v_o", tag, i), v_o, tbl[i].e_v);
      chk($sformatf("%s[%0d].invalid_cache_o", tag, i), invalid_cache_o, tbl[i].e_inv);
      chk($sformatf("%s[%0d].key_valid_o", tag, i), key_valid_o, tbl[i].e_kval);
    end
    tbl.delete();
  endtask

  initial begin
    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst.v_o", v_o, 0);
    chk("rst.key_valid_o", key_valid_o, 0);
    chk("rst.invalid_cache_o", invalid_cache_o, 0);
    chk("rst.key_o", key_o, 0);
    chk("rst.content_o", content_o, 0);
    chk("rst.mode_o", encode_or_decode_o, 0);
    reset_i = 1'b0;
    #1;
    chk("rst.ready_o", ready_o, 1);

    // 1: key then data, same words; mode 1 on word 0, 0 afterwards (ignored)
    //  rst v  k  word          m  rdy  ready v inv kval
    add(1, 1, 1, 32'h01234567, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'h89abcdef, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'hfedcba98, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'h76543210, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 32'h01234567, 1, 1,   1, 0, 1, 1);
    add(0, 1, 0, 32'h89abcdef, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 32'hfedcba98, 0, 1,   1, 0, 0, 1);
    add(0, 1, 0, 32'h76543210, 0, 1,   1, 0, 0, 1);
    add(0, 0, 0, 32'h0,        0, 1,   0, 1, 0, 1);
    add(0, 0, 0, 32'h0,        0, 1,   1, 0, 0, 1);
    run_table("t1");
    chk("t1.key_o", key_o, 128'h0123456789abcdeffedcba9876543210);
    chk("t1.content_o", content_o, 128'h0123456789abcdeffedcba9876543210);
    chk("t1.mode_o", encode_or_decode_o, 1);

    // 2: data before any key -> HOLD; only key words accepted there
    add(1, 1, 0, 32'hd0000000, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 32'hd1000000, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 32'hd2000000, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 32'hd3000000, 0, 1,   1, 0, 0, 0);
    add(0, 1, 0, 32'hdead0000, 1, 1,   0, 0, 0, 0);
    add(0, 1, 1, 32'ha5a5a5a5, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'h5a5a5a5a, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'h0f0f0f0f, 0, 1,   1, 0, 0, 0);
    add(0, 1, 1, 32'hf0f0f0f0, 0, 1,   1, 0, 0, 0);
    add(0, 0, 0, 32'h0,        0, 1,   0, 0, 1, 1);
    add(0, 0, 0, 32'h0,        0, 1,   0, 1, 0, 1);
    add(0, 0, 0, 32'h0,        0, 1,   1, 0, 0, 1);
    run_table("t2");
    chk("t2.content_o", content_o, 128'hd0000000d1000000d2000000d3000000);
    chk("t2.key_o", key_o, 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0);
    chk("t2.mode_o", encode_or_decode_o, 0);

    // 3: pending group with encryptor back-pressure; key words offered meanwhile
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 32'(i), 1, 0, 0);
      chk($sformatf("t3.d%0d.ready_o", i), ready_o, 1);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 32'hffffffff, 0, 0, 0);
      chk($sformatf("t3.w%0d.v_o", i), v_o, 1);
      chk($sformatf("t3.w%0d.ready_o", i), ready_o, 0);
      chk($sformatf("t3.w%0d.content_o", i), content_o, 128'h00000001000000020000000300000004);
      chk($sformatf("t3.w%0d.key_o", i), key_o, 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0);
      chk($sformatf("t3.w%0d.inv", i), invalid_cache_o, 0);
    end
    chk("t3.mode_o", encode_or_decode_o, 1);
    drive(0, 0, 0, 0, 1, 0);
    chk("t3.xfer.v_o", v_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t3.after.ready_o", ready_o, 1);
    chk("t3.after.v_o", v_o, 0);

    // 4: interleaved key and data words
    add(1, 1, 1, 32'h11111111, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 32'ha0000000, 0, 0,   1, 0, 0, 0);
    add(0, 1, 1, 32'h22222222, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 32'ha1000000, 0, 0,   1, 0, 0, 0);
    add(0, 1, 1, 32'h33333333, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 32'ha2000000, 0, 0,   1, 0, 0, 0);
    add(0, 1, 1, 32'h44444444, 0, 0,   1, 0, 0, 0);
    add(0, 1, 0, 32'ha3000000, 0, 0,   1, 0, 1, 1);
    add(0, 0, 0, 32'h0,        0, 0,   0, 1, 0, 1);
    run_table("t4");
    chk("t4.key_o", key_o, 128'h11111111222222223333333344444444);
    chk("t4.content_o", content_o, 128'ha0000000a1000000a2000000a3000000);

    // 5: clear after two data words (a word offered with clear is dropped)
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 32'h12345678, 0, 0, 0);
    drive(1, 0, 32'h9abcdef0, 0, 0, 0);
    drive(1, 0, 32'h99999999, 0, 0, 1);
    chk("t5.clr.inv", invalid_cache_o, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'hc0000000 + (32'(i) << 24), 0, 0, 0);
      chk($sformatf("t5.d%0d.ready_o", i), ready_o, 1);
      chk($sformatf("t5.d%0d.inv", i), invalid_cache_o, 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("t5.v_o", v_o, 1);
    chk("t5.content_o", content_o, 128'hc0000000c1000000c2000000c3000000);
    chk("t5.key_o", key_o, 128'h11111111222222223333333344444444);
    chk("t5.key_valid_o", key_valid_o, 1);
    chk("t5.inv", invalid_cache_o, 0);

    // 6: asynchronous reset in the middle of SEND
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6.v_o", v_o, 0);
    chk("t6.key_valid_o", key_valid_o, 0);
    chk("t6.key_o", key_o, 0);
    chk("t6.content_o", content_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("t6.rel.ready_o", ready_o, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6.next.ready_o", ready_o, 1);
    chk("t6.next.v_o", v_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
